// File: rtl/pipe_seq_ctrl.sv
// Pipeline sequencing controller: load-use stalls, EX redirect flushes and
// Halt draining, with a saturating count of load-use stall cycles.
module pipe_seq_ctrl #(
    parameter int DRAIN_CYCLES = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        id_ex_memread,
    input  logic [4:0]  id_ex_rd,
    input  logic [4:0]  if_id_rs1,
    input  logic [4:0]  if_id_rs2,
    input  logic        use_rs1,
    input  logic        use_rs2,
    input  logic        ex_redirect,
    input  logic        id_halt,
    output logic        pc_write,
    output logic        if_id_write,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        halted,
    output logic [1:0]  state,
    output logic [15:0] stall_cnt
);

    localparam logic [1:0] RUN    = 2'b00;
    localparam logic [1:0] DRAIN  = 2'b01;
    localparam logic [1:0] HALTED = 2'b10;

    localparam int CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CW-1:0] DRAIN_LOAD = CW'(DRAIN_CYCLES - 1);

    logic [CW-1:0] drain_cnt;
    logic [CW-1:0] drain_cnt_next;
    logic [1:0]    state_next;
    logic          stall_inc;
    logic          redirect_eff;
    logic          halt_eff;
    logic          lu;

    // While reset is held every input is treated as 0, so the outputs look like an idle RUN cycle.
    assign redirect_eff = reset & ex_redirect;
    assign halt_eff     = reset & id_halt;
    assign lu = reset & id_ex_memread & (id_ex_rd != 5'd0) &
                ((use_rs1 & (if_id_rs1 == id_ex_rd)) | (use_rs2 & (if_id_rs2 == id_ex_rd)));

    always_comb begin
        pc_write       = 1'b0;
        if_id_write    = 1'b0;
        if_id_flush    = 1'b0;
        id_ex_flush    = 1'b1;
        state_next     = state;
        drain_cnt_next = drain_cnt;
        stall_inc      = 1'b0;
        case (state)
            RUN: begin
                if (redirect_eff) begin
                    pc_write    = 1'b1;
                    if_id_write = 1'b1;
                    if_id_flush = 1'b1;
                end else if (lu) begin
                    stall_inc = 1'b1;
                end else if (halt_eff) begin
                    if (DRAIN_CYCLES <= 1) begin
                        state_next     = HALTED;
                        drain_cnt_next = '0;
                    end else begin
                        state_next     = DRAIN;
                        drain_cnt_next = DRAIN_LOAD;
                    end
                end else begin
                    pc_write    = 1'b1;
                    if_id_write = 1'b1;
                    id_ex_flush = 1'b0;
                end
            end
            DRAIN: begin
                // The edge that takes the counter down to 0 is the last DRAIN cycle.
                if (drain_cnt <= CW'(1)) begin
                    state_next     = HALTED;
                    drain_cnt_next = '0;
                end else begin
                    drain_cnt_next = drain_cnt - CW'(1);
                end
            end
            HALTED: begin
                state_next = HALTED;
            end
            default: begin
                state_next     = RUN;
                drain_cnt_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= RUN;
            drain_cnt <= '0;
            stall_cnt <= 16'd0;
            halted    <= 1'b0;
        end else begin
            state     <= state_next;
            drain_cnt <= drain_cnt_next;
            halted    <= (state_next == HALTED);
            if (stall_inc && (stall_cnt != 16'hFFFF)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_seq_ctrl.sv
// Directed bench for pipe_seq_ctrl: stimulus pushes hand-computed expectations,
// a monitor on the falling edge pops and compares them.
module tb_pipe_seq_ctrl;

    logic        clk;
    logic        reset;
    logic        id_ex_memread;
    logic [4:0]  id_ex_rd;
    logic [4:0]  if_id_rs1;
    logic [4:0]  if_id_rs2;
    logic        use_rs1;
    logic        use_rs2;
    logic        ex_redirect;
    logic        id_halt;
    logic        pc_write;
    logic        if_id_write;
    logic        if_id_flush;
    logic        id_ex_flush;
    logic        halted;
    logic [1:0]  state;
    logic [15:0] stall_cnt;

    typedef struct {
        string       name;
        logic        pc_write;
        logic        if_id_write;
        logic        if_id_flush;
        logic        id_ex_flush;
        logic [1:0]  state;
        logic        halted;
        logic [15:0] stall_cnt;
    } exp_t;

    exp_t exp_q[$];
    int   num_checks = 0;
    int   num_fails  = 0;

    pipe_seq_ctrl #(.DRAIN_CYCLES(3)) dut (
        .clk           (clk),
        .reset         (reset),
        .id_ex_memread (id_ex_memread),
        .id_ex_rd      (id_ex_rd),
        .if_id_rs1     (if_id_rs1),
        .if_id_rs2     (if_id_rs2),
        .use_rs1       (use_rs1),
        .use_rs2       (use_rs2),
        .ex_redirect   (ex_redirect),
        .id_halt       (id_halt),
        .pc_write      (pc_write),
        .if_id_write   (if_id_write),
        .if_id_flush   (if_id_flush),
        .id_ex_flush   (id_ex_flush),
        .halted        (halted),
        .state         (state),
        .stall_cnt     (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic compareField(input string vec, input string field,
                                input logic [15:0] got, input logic [15:0] want);
        num_checks++;
        if (got !== want) begin
            num_fails++;
            $display("[TB] FAIL %s.%s: got %0h, expected %0h", vec, field, got, want);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        compareField(e.name, "pc_write",    16'(pc_write),    16'(e.pc_write));
        compareField(e.name, "if_id_write", 16'(if_id_write), 16'(e.if_id_write));
        compareField(e.name, "if_id_flush", 16'(if_id_flush), 16'(e.if_id_flush));
        compareField(e.name, "id_ex_flush", 16'(id_ex_flush), 16'(e.id_ex_flush));
        compareField(e.name, "state",       16'(state),       16'(e.state));
        compareField(e.name, "halted",      16'(halted),      16'(e.halted));
        compareField(e.name, "stall_cnt",   stall_cnt,        e.stall_cnt);
    endtask

    // Monitor: every falling edge, compare against the oldest pending expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput(e);
            end
        end
    end

    task automatic driveInputs(input logic mr, input logic [4:0] rd, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic u1, input logic u2,
                               input logic redir, input logic halt);
        id_ex_memread = mr;
        id_ex_rd      = rd;
        if_id_rs1     = rs1;
        if_id_rs2     = rs2;
        use_rs1       = u1;
        use_rs2       = u2;
        ex_redirect   = redir;
        id_halt       = halt;
    endtask

    // Called just after a rising edge: drive one cycle and queue what it must produce.
    task automatic applyStimulus(input string name,
                                 input logic mr, input logic [4:0] rd, input logic [4:0] rs1,
                                 input logic [4:0] rs2, input logic u1, input logic u2,
                                 input logic redir, input logic halt,
                                 input logic e_pcw, input logic e_ifw, input logic e_iff,
                                 input logic e_exf, input logic [1:0] e_st, input logic e_h,
                                 input logic [15:0] e_cnt);
        exp_t e;
        driveInputs(mr, rd, rs1, rs2, u1, u2, redir, halt);
        e.name        = name;
        e.pc_write    = e_pcw;
        e.if_id_write = e_ifw;
        e.if_id_flush = e_iff;
        e.id_ex_flush = e_exf;
        e.state       = e_st;
        e.halted      = e_h;
        e.stall_cnt   = e_cnt;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, queue depth %0d", exp_q.size());
        $fatal(1, "[TB] timeout");
    end

    initial begin
        reset = 1'b0;
        driveInputs(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;

        // Held in reset with every event asserted: must look like idle RUN.
        applyStimulus("rst_mask", 1, 5'd5, 5'd5, 5'd5, 1, 1, 1, 1,  1, 1, 0, 0, 2'b00, 0, 16'd0);
        reset = 1'b1;
        applyStimulus("idle",     0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0,  1, 1, 0, 0, 2'b00, 0, 16'd0);
        applyStimulus("lu_rs1",   1, 5'd5, 5'd5, 5'd0, 1, 0, 0, 0,  0, 0, 0, 1, 2'b00, 0, 16'd0);
        applyStimulus("after_lu", 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0,  1, 1, 0, 0, 2'b00, 0, 16'd1);
        applyStimulus("x0",       1, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0,  1, 1, 0, 0, 2'b00, 0, 16'd1);
        applyStimulus("nouse",    1, 5'd5, 5'd0, 5'd5, 0, 0, 0, 0,  1, 1, 0, 0, 2'b00, 0, 16'd1);
        applyStimulus("lu_rs2",   1, 5'd7, 5'd1, 5'd7, 0, 1, 0, 0,  0, 0, 0, 1, 2'b00, 0, 16'd1);
        applyStimulus("prio",     1, 5'd5, 5'd5, 5'd0, 1, 0, 1, 1,  1, 1, 1, 1, 2'b00, 0, 16'd2);
        applyStimulus("post_pri", 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0,  1, 1, 0, 0, 2'b00, 0, 16'd2);
        applyStimulus("redirect", 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0,  1, 1, 1, 1, 2'b00, 0, 16'd2);

        // Halt drain with a redirect and a load-use arriving while draining.
        applyStimulus("halt_N",   0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1,  0, 0, 0, 1, 2'b00, 0, 16'd2);
        applyStimulus("drain_N1", 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0,  0, 0, 0, 1, 2'b01, 0, 16'd2);
        applyStimulus("drain_N2", 1, 5'd5, 5'd5, 5'd0, 1, 0, 0, 0,  0, 0, 0, 1, 2'b01, 0, 16'd2);
        applyStimulus("halt_N3",  0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0,  0, 0, 0, 1, 2'b10, 1, 16'd2);
        applyStimulus("halt_N4",  1, 5'd3, 5'd3, 5'd3, 1, 1, 1, 1,  0, 0, 0, 1, 2'b10, 1, 16'd2);

        reset = 1'b0;
        applyStimulus("rst_halt", 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0,  1, 1, 0, 0, 2'b00, 0, 16'd0);
        reset = 1'b1;
        applyStimulus("run_a",    0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0,  1, 1, 0, 0, 2'b00, 0, 16'd0);
        applyStimulus("lu_a",     1, 5'd9, 5'd9, 5'd0, 1, 0, 0, 0,  0, 0, 0, 1, 2'b00, 0, 16'd0);
        applyStimulus("run_b",    0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0,  1, 1, 0, 0, 2'b00, 0, 16'd1);
        applyStimulus("halt_b",   0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1,  0, 0, 0, 1, 2'b00, 0, 16'd1);
        applyStimulus("drain_b",  0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0,  0, 0, 0, 1, 2'b01, 0, 16'd1);
        reset = 1'b0;
        applyStimulus("rst_drn",  0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0,  1, 1, 0, 0, 2'b00, 0, 16'd0);
        reset = 1'b1;

        // A fresh halt must take the full drain length: no leftover count.
        applyStimulus("run_c",    0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0,  1, 1, 0, 0, 2'b00, 0, 16'd0);
        applyStimulus("halt_c",   0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1,  0, 0, 0, 1, 2'b00, 0, 16'd0);
        applyStimulus("drain_c1", 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0,  0, 0, 0, 1, 2'b01, 0, 16'd0);
        applyStimulus("drain_c2", 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0,  0, 0, 0, 1, 2'b01, 0, 16'd0);
        applyStimulus("halted_c", 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0,  0, 0, 0, 1, 2'b10, 1, 16'd0);

        reset = 1'b0;
        applyStimulus("rst_sat",  0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0,  1, 1, 0, 0, 2'b00, 0, 16'd0);
        reset = 1'b1;

        // 70000 load-use cycles push the counter well past its ceiling.
        driveInputs(1'b1, 5'd4, 5'd4, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (70000) @(posedge clk);
        #1;
        applyStimulus("sat_lu",   1, 5'd4, 5'd4, 5'd0, 1, 0, 0, 0,  0, 0, 0, 1, 2'b00, 0, 16'hFFFF);
        applyStimulus("sat_idle", 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0,  1, 1, 0, 0, 2'b00, 0, 16'hFFFF);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            num_checks++;
            num_fails++;
            $display("[TB] FAIL drain_queue: got %0d pending, expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
        $finish;
    end

endmodule

// File: doc/pipe_seq_ctrl.md
PIPE_SEQ_CTRL -- requirements
Module: pipe_seq_ctrl

Interface
REQ-001 Parameter: DRAIN_CYCLES, default 3, number of cycles needed to retire the instructions older than a Halt (EX, MEM, WB).
REQ-002 Clocking: one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  asynchronous, active-low reset (0 = reset).
REQ-005 id_ex_memread  input  1  MemRead of the instruction in EX (load in EX).
REQ-006 id_ex_rd  input  5  destination register of the instruction in EX.
REQ-007 if_id_rs1, if_id_rs2  input  5 each  source registers of the instruction in ID.
REQ-008 use_rs1, use_rs2  input  1 each  ID instruction actually reads rs1 / rs2.
REQ-009 ex_redirect  input  1  taken branch, or JAL/JALR resolved in EX; PC takes the target this cycle.
REQ-010 id_halt  input  1  Halt opcode (7'b1111111) decoded in ID.
REQ-011 pc_write  output  1  PC register enable.
REQ-012 if_id_write  output  1  IF/ID register enable.
REQ-013 if_id_flush  output  1  IF/ID register loads a bubble.
REQ-014 id_ex_flush  output  1  ID/EX control fields are zeroed (bubble).
REQ-015 halted  output  1  pipeline fully drained and stopped.
REQ-016 state  output  2  FSM state: RUN=00, DRAIN=01, HALTED=10; 11 is unused.
REQ-017 stall_cnt  output  16  count of load-use stall cycles, saturating.

Function
REQ-018 A load-use hazard (lu) SHALL be: id_ex_memread=1, id_ex_rd!=0, and (use_rs1 with rs1==id_ex_rd, or use_rs2 with rs2==id_ex_rd).
REQ-019 All outputs other than state, halted and stall_cnt SHALL be combinational from the current state and the inputs, with zero-cycle latency.
REQ-020 In RUN, the priority SHALL be ex_redirect > lu > id_halt.
REQ-021 RUN, ex_redirect=1: pc_write=1, if_id_write=1, if_id_flush=1, id_ex_flush=1; lu and id_halt are ignored; the state stays RUN.
REQ-022 RUN, lu without redirect: pc_write=0, if_id_write=0, if_id_flush=0, id_ex_flush=1; the state stays RUN; stall_cnt increments at the clock edge.
REQ-023 stall_cnt SHALL saturate at 16'hFFFF and never wrap.
REQ-024 RUN, id_halt without redirect or lu: pc_write=0, if_id_write=0, id_ex_flush=1; the drain counter loads DRAIN_CYCLES-1; the next state is DRAIN.
REQ-025 RUN with no event: pc_write=1, if_id_write=1, and both flushes are 0.
REQ-026 DRAIN: pc_write=0, if_id_write=0, id_ex_flush=1, if_id_flush=0; the counter decrements each cycle; when it is 0 at a clock edge, the next state is HALTED.
REQ-027 DRAIN lasts exactly DRAIN_CYCLES-1 cycles, so the cycle with the Halt in ID plus DRAIN spans DRAIN_CYCLES cycles.
REQ-028 If DRAIN_CYCLES=1, the transition SHALL go from RUN directly to HALTED.
REQ-029 In DRAIN, ex_redirect, lu and id_halt SHALL be ignored, because no older control transfer can remain in EX.
REQ-030 HALTED: pc_write=0, if_id_write=0, id_ex_flush=1, if_id_flush=0, halted=1.
REQ-031 HALTED SHALL be absorbing; only reset exits it.
REQ-032 halted SHALL be registered and equal to 1 exactly when the state is HALTED.
REQ-033 X-safety: an unused state encoding (11) SHALL go to RUN at the next edge, and its outputs SHALL equal those of HALTED.

Reset
REQ-034 While reset=0, asynchronously: state=RUN, drain counter=0, stall_cnt=0, halted=0.
REQ-035 While reset=0, the combinational outputs follow RUN with all inputs treated as 0: pc_write=1, if_id_write=1, both flushes 0.
REQ-036 Reset asserted mid-DRAIN or in HALTED SHALL return the block to RUN on the first rising edge after deassertion, with no residual count.

Verification
REQ-037 Load-use: id_ex_memread=1, rd=5, rs1=5, use_rs1=1 for 1 cycle -> pc_write=0, if_id_write=0, id_ex_flush=1 that cycle; stall_cnt goes 0->1.
REQ-038 x0 and non-use cases: rd=0 with rs1=0, or rd=5, rs2=5, use_rs2=0 -> no stall; pc_write=1; stall_cnt unchanged.
REQ-039 Priority: ex_redirect=1, lu=1 and id_halt=1 in the same cycle -> both flushes 1, pc_write=1, state stays RUN, stall_cnt unchanged.
REQ-040 Halt drain, DRAIN_CYCLES=3: id_halt pulse at cycle N -> state=DRAIN at N+1 and N+2, HALTED at N+3, halted=1 from N+3; pc_write=0 from N onward; a later ex_redirect=1 has no effect.
REQ-041 Saturation: force 70000 consecutive lu cycles -> stall_cnt holds 16'hFFFF.
REQ-042 Reset: reset=0 asserted asynchronously in DRAIN and in HALTED -> state=00, halted=0, stall_cnt=0 immediately; normal RUN behaviour after deassertion.
